// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes, funct codes, ALU codes.
// No logic of its own; imported by mc_controller and mc_aludec.
// Optional ORI support (macro MC_CTRL_ORI_EN) only adds states here; encodings stay fixed.
package mips_ctrl_pkg;

    // Width of the state encodings below; the controller's STATE_W must be at least this.
    localparam int STATE_ENC_W = 4;

    typedef enum logic [STATE_ENC_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_ORIEX   = 4'd12,
        S_ORIWB   = 4'd13
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Coarse ALU request from the FSM, refined by mc_aludec
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // LW and SW share the address-calculation path
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop request plus R-type funct to a 3-bit ALU control code.
// Purely combinational, zero latency.
// No handshake; output follows inputs.
module mc_aludec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Fixed ops pass straight through; funct-driven ops fall back to add for unknown codes
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_OR:  alucontrol = ALU_OR;
            default: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM (fetch/decode/execute/mem/writeback) plus ALU decoder.
// Outputs are combinational from the state register (pcen also uses zero); one state per cycle.
// No backpressure; reset forces all write enables low. Macro MC_CTRL_ORI_EN adds ORI support.
module mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4   // must be >= 4 to hold every state encoding
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       immsrc
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_nx;
    logic [STATE_W-1:0] cur_state;

    // Raw Moore outputs before reset gating
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    logic       pcwrite;
    logic       branch;
    logic       alu_act;
    logic [1:0] aluop;
    logic [2:0] alu_dec;
`ifdef MC_CTRL_ORI_EN
    logic       immsrc_s;
`endif

    // State register; reset returns to FETCH, aborting any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_W'(S_FETCH);
        end else begin
            state_q <= state_nx;
        end
    end

    // While reset is high the outputs must look like FETCH, so decode FETCH instead of state_q
    assign cur_state = reset ? STATE_W'(S_FETCH) : state_q;

    // Next-state and Moore outputs; everything defaults to 0 and each state raises only its own strobes
    always_comb begin
        state_nx   = STATE_W'(S_FETCH);
        iord       = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        alu_act    = 1'b0;
        aluop      = ALUOP_ADD;
`ifdef MC_CTRL_ORI_EN
        immsrc_s   = 1'b0;
`endif
        case (cur_state)
            STATE_W'(S_FETCH): begin
                alusrcb   = 2'b01;
                alu_act   = 1'b1;
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
                state_nx  = STATE_W'(S_DECODE);
            end
            STATE_W'(S_DECODE): begin
                // Precompute the branch target into ALUOut while the opcode is decoded
                alusrcb = 2'b11;
                alu_act = 1'b1;
                if (is_mem_op(op))        state_nx = STATE_W'(S_MEMADR);
                else if (op == OP_RTYPE)  state_nx = STATE_W'(S_RTYPEEX);
                else if (op == OP_BEQ)    state_nx = STATE_W'(S_BEQEX);
                else if (op == OP_ADDI)   state_nx = STATE_W'(S_ADDIEX);
                else if (op == OP_J)      state_nx = STATE_W'(S_JEX);
`ifdef MC_CTRL_ORI_EN
                else if (op == OP_ORI)    state_nx = STATE_W'(S_ORIEX);
`endif
                else                      state_nx = STATE_W'(S_FETCH);
            end
            STATE_W'(S_MEMADR): begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                alu_act  = 1'b1;
                state_nx = (op == OP_LW) ? STATE_W'(S_MEMRD) : STATE_W'(S_MEMWR);
            end
            STATE_W'(S_MEMRD): begin
                iord     = 1'b1;
                state_nx = STATE_W'(S_MEMWB);
            end
            STATE_W'(S_MEMWB): begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            STATE_W'(S_MEMWR): begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            STATE_W'(S_RTYPEEX): begin
                alusrca  = 1'b1;
                alu_act  = 1'b1;
                aluop    = ALUOP_FUNCT;
                state_nx = STATE_W'(S_RTYPEWB);
            end
            STATE_W'(S_RTYPEWB): begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            STATE_W'(S_BEQEX): begin
                alusrca = 1'b1;
                alu_act = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            STATE_W'(S_ADDIEX): begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                alu_act  = 1'b1;
                state_nx = STATE_W'(S_ADDIWB);
            end
            STATE_W'(S_ADDIWB): begin
                regwrite_s = 1'b1;
            end
            STATE_W'(S_JEX): begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MC_CTRL_ORI_EN
            STATE_W'(S_ORIEX): begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                alu_act  = 1'b1;
                aluop    = ALUOP_OR;
                immsrc_s = 1'b1;
                state_nx = STATE_W'(S_ORIWB);
            end
            STATE_W'(S_ORIWB): begin
                regwrite_s = 1'b1;
                immsrc_s   = 1'b1;
            end
`endif
            default: begin
                // Unused encodings recover to FETCH with every output at 0
                state_nx = STATE_W'(S_FETCH);
            end
        endcase
    end

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alu_dec)
    );

    // States that do not use the ALU present 000 rather than a stale decode
    assign alucontrol = alu_act ? alu_dec : 3'b000;

    // Write strobes are suppressed at the edge where reset is sampled
    assign irwrite  = irwrite_s  & ~reset;
    assign memwrite = memwrite_s & ~reset;
    assign regwrite = regwrite_s & ~reset;
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;

`ifdef MC_CTRL_ORI_EN
    assign immsrc = immsrc_s;
`else
    assign immsrc = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction sequence with a per-cycle scoreboard.
// Expected control vectors are queued per instruction and compared one per cycle at the falling edge.
// Covers reset, every opcode path, BEQ taken/not taken, unsupported ops and mid-instruction reset.
module tb_mc_controller;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] alucontrol;
        logic       immsrc;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen, immsrc;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int checks   = 0;
    int failures = 0;

    ctl_t  exp_q[$];
    string tag_q[$];
    ctl_t  obs;

    mc_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
        .immsrc     (immsrc)
    );

    always #5 clk = ~clk;

    assign obs = '{iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                   alusrcb, pcsrc, pcen, alucontrol, immsrc};

    // Expected vectors, one per controller phase
    function automatic ctl_t v_reset();
        ctl_t c = '0;
        c.alusrcb = 2'b01; c.alucontrol = 3'b010;
        return c;
    endfunction
    function automatic ctl_t v_fetch();
        ctl_t c = '0;
        c.irwrite = 1'b1; c.pcen = 1'b1; c.alusrcb = 2'b01; c.alucontrol = 3'b010;
        return c;
    endfunction
    function automatic ctl_t v_decode();
        ctl_t c = '0;
        c.alusrcb = 2'b11; c.alucontrol = 3'b010;
        return c;
    endfunction
    function automatic ctl_t v_addr_imm(input logic [2:0] alu, input logic imm);
        ctl_t c = '0;
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = alu; c.immsrc = imm;
        return c;
    endfunction
    function automatic ctl_t v_wb(input logic dst, input logic m2r, input logic imm);
        ctl_t c = '0;
        c.regwrite = 1'b1; c.regdst = dst; c.memtoreg = m2r; c.immsrc = imm;
        return c;
    endfunction
    function automatic ctl_t v_rtypeex(input logic [5:0] f);
        ctl_t c = '0;
        c.alusrca = 1'b1;
        case (f)
            6'b100000: c.alucontrol = 3'b010;
            6'b100010: c.alucontrol = 3'b110;
            6'b100100: c.alucontrol = 3'b000;
            6'b100101: c.alucontrol = 3'b001;
            6'b101010: c.alucontrol = 3'b111;
            default:   c.alucontrol = 3'b010;
        endcase
        return c;
    endfunction

    task automatic push(input ctl_t c, input string tag);
        exp_q.push_back(c);
        tag_q.push_back(tag);
    endtask

    // Compare one queued vector per cycle at the falling edge, then move to just past the next rising edge
    task automatic drain();
        ctl_t  e;
        string t;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the full expected phase sequence for one instruction, then run it
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input string name);
        ctl_t c;
        op = o; funct = f; zero = z;
        push(v_fetch(),  {name, "_fetch"});
        push(v_decode(), {name, "_decode"});
        case (o)
            6'b100011: begin
                push(v_addr_imm(3'b010, 1'b0), {name, "_memadr"});
                c = '0; c.iord = 1'b1;
                push(c, {name, "_memrd"});
                push(v_wb(1'b0, 1'b1, 1'b0), {name, "_memwb"});
            end
            6'b101011: begin
                push(v_addr_imm(3'b010, 1'b0), {name, "_memadr"});
                c = '0; c.iord = 1'b1; c.memwrite = 1'b1;
                push(c, {name, "_memwr"});
            end
            6'b000000: begin
                push(v_rtypeex(f), {name, "_rtypeex"});
                push(v_wb(1'b1, 1'b0, 1'b0), {name, "_rtypewb"});
            end
            6'b000100: begin
                c = '0; c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z;
                push(c, {name, "_beqex"});
            end
            6'b001000: begin
                push(v_addr_imm(3'b010, 1'b0), {name, "_addiex"});
                push(v_wb(1'b0, 1'b0, 1'b0), {name, "_addiwb"});
            end
            6'b000010: begin
                c = '0; c.pcsrc = 2'b10; c.pcen = 1'b1;
                push(c, {name, "_jex"});
            end
`ifdef MC_CTRL_ORI_EN
            6'b001101: begin
                push(v_addr_imm(3'b001, 1'b1), {name, "_oriex"});
                push(v_wb(1'b0, 1'b0, 1'b1), {name, "_oriwb"});
            end
`endif
            default: ;
        endcase
        drain();
    endtask

    initial begin
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
        @(posedge clk);
        #1;
        // Reset held: FETCH view with all enables low
        push(v_reset(), "reset_hold");
        drain();
        reset = 1'b0;

        do_instr(6'b100011, 6'b000000, 1'b0, "lw");
        do_instr(6'b000000, 6'b101010, 1'b0, "r_slt");
        do_instr(6'b000000, 6'b100010, 1'b1, "r_sub");
        do_instr(6'b000000, 6'b100100, 1'b0, "r_and");
        do_instr(6'b000000, 6'b100101, 1'b0, "r_or");
        do_instr(6'b000000, 6'b100000, 1'b0, "r_add");
        do_instr(6'b000000, 6'b111111, 1'b0, "r_unk");
        do_instr(6'b000100, 6'b000000, 1'b1, "beq_t");
        do_instr(6'b000100, 6'b000000, 1'b0, "beq_nt");
        do_instr(6'b101011, 6'b000000, 1'b1, "sw");
        do_instr(6'b000010, 6'b000000, 1'b0, "j");
        do_instr(6'b001000, 6'b000000, 1'b0, "addi");
        do_instr(6'b111111, 6'b000000, 1'b0, "bad_op");
        do_instr(6'b001101, 6'b000000, 1'b0, "ori");

        // Reset during MEMADR of a load: enables low, then FETCH on the following cycle
        op = 6'b100011; zero = 1'b0;
        push(v_fetch(), "rst1_fetch");
        push(v_decode(), "rst1_decode");
        drain();
        reset = 1'b1;
        push(v_reset(), "rst1_memadr");
        drain();
        reset = 1'b0;
        do_instr(6'b100011, 6'b000000, 1'b0, "lw_after_rst1");

        // Reset during MEMWB: the register write must be suppressed
        op = 6'b100011;
        push(v_fetch(), "rst2_fetch");
        push(v_decode(), "rst2_decode");
        push(v_addr_imm(3'b010, 1'b0), "rst2_memadr");
        push('{iord: 1'b1, default: '0}, "rst2_memrd");
        drain();
        reset = 1'b1;
        push(v_reset(), "rst2_memwb");
        drain();
        reset = 1'b0;
        do_instr(6'b000010, 6'b000000, 1'b0, "j_after_rst2");

        // Final return to FETCH after the last instruction
        push(v_fetch(), "final_fetch");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
